// File: rtl/load_store_controller_pkg.sv
// rtl/load_store_controller_pkg.sv - LSU opcodes, funct3/error codes and FSM state type
// LSU_MISALIGNED_SPLIT_EN adds the ACCESS2 state.
package load_store_controller_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_DOUBLEWORD    = 3'b011;
    localparam logic [2:0] F3_WORD_UNSIGNED = 3'b110;
    localparam logic [2:0] F3_INVALID       = 3'b111;

    localparam logic [1:0] ERR_OK         = 2'b00;
    localparam logic [1:0] ERR_MISALIGNED = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL    = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
`ifdef LSU_MISALIGNED_SPLIT_EN
        , S_ACCESS2
`endif
    } state_t;

    // Address bits that must be zero for a naturally aligned access of this size.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        return 3'((4'd1 << size) - 4'd1);
    endfunction

endpackage

// File: rtl/load_store_controller_if.sv
// rtl/load_store_controller_if.sv - data-memory bus between the LSU (master) and memory (slave)
interface load_store_controller_if #(
    parameter int XLEN          = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic                     mem_valid;
    logic                     mem_write;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [XLEN/8-1:0]        mem_wmask;
    logic [XLEN-1:0]          mem_wdata;
    logic                     mem_ready;
    logic [XLEN-1:0]          mem_rdata;

    modport master (
        output mem_valid, mem_write, mem_addr, mem_wmask, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_write, mem_addr, mem_wmask, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/load_store_controller_lane_align.sv
// rtl/load_store_controller_lane_align.sv - byte-lane mask/shift and load extraction/extension
// LSU_MISALIGNED_SPLIT_EN exposes the spill-over lanes for the second beat.
module load_store_controller_lane_align #(
    parameter  int XLEN = 32,
    localparam int NB   = XLEN / 8,
    localparam int OW   = $clog2(NB)
) (
    input  logic [2:0]      funct3,
    input  logic [OW-1:0]   offset,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata_lo,
`ifdef LSU_MISALIGNED_SPLIT_EN
    input  logic [XLEN-1:0] rdata_hi,
    output logic [NB-1:0]   wmask_hi,
    output logic [XLEN-1:0] wdata_hi,
`endif
    output logic [NB-1:0]   wmask,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data
);
    localparam int IW = $clog2(2 * XLEN);

    logic [3:0]        nbytes;
    logic [6:0]        nbits;
    logic [7:0]        size_mask;
    logic [2*XLEN-1:0] rdata_wide;
    logic [2*XLEN-1:0] shifted;
    logic [XLEN-1:0]   keep;
    logic              sign;

    always_comb begin
        nbytes    = 4'd1 << funct3[1:0];
        nbits     = {nbytes, 3'b000};
        size_mask = 8'((9'd1 << nbytes) - 9'd1);
    end

`ifdef LSU_MISALIGNED_SPLIT_EN
    assign {wmask_hi, wmask} = (2*NB)'(size_mask) << offset;
    assign {wdata_hi, wdata} = {{XLEN{1'b0}}, store_data} << {offset, 3'b000};
    assign rdata_wide        = {rdata_hi, rdata_lo};
`else
    assign wmask      = NB'(size_mask << offset);
    assign wdata      = store_data << {offset, 3'b000};
    assign rdata_wide = {{XLEN{1'b0}}, rdata_lo};
`endif

    // Shifting the two-word window lets a split load merge both beats for free.
    always_comb begin
        shifted   = rdata_wide >> {offset, 3'b000};
        keep      = XLEN'((65'd1 << nbits) - 65'd1);
        sign      = ~funct3[2] & shifted[IW'(nbits - 7'd1)];
        load_data = (shifted[XLEN-1:0] & keep) | ({XLEN{sign}} & ~keep);
    end

endmodule

// File: rtl/load_store_controller.sv
// rtl/load_store_controller.sv - handshaked load/store FSM and registered bus request
// LSU_MISALIGNED_SPLIT_EN splits misaligned legal accesses into two bus beats.
module load_store_controller
    import load_store_controller_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [6:0]              opcode,
    input  logic [2:0]              funct3,
    input  logic [XLEN-1:0]         address,
    input  logic [XLEN-1:0]         store_data,
    load_store_controller_if.master mem,
    output logic                    resp_valid,
    output logic [1:0]              resp_error,
    output logic [XLEN-1:0]         load_data
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    state_t                   state, state_next;
    logic                     op_write;
    logic [2:0]               op_funct3;
    logic [OW-1:0]            op_offset;
    logic                     illegal, misaligned;
    logic [1:0]               dec_error;
    logic [ADDRESS_WIDTH-1:0] aligned_addr;
    logic                     in_idle;
    logic [2:0]               la_funct3;
    logic [OW-1:0]            la_offset;
    logic [XLEN-1:0]          la_rdata_lo;
    logic [NB-1:0]            la_wmask;
    logic [XLEN-1:0]          la_wdata, la_load;
`ifdef LSU_MISALIGNED_SPLIT_EN
    logic                     op_split;
    logic [NB-1:0]            la_wmask_hi, wmask_hi;
    logic [XLEN-1:0]          la_wdata_hi, wdata_hi, rdata_lo;
`endif

    always_comb begin
        illegal = (opcode != OPC_LOAD && opcode != OPC_STORE) || funct3 == F3_INVALID
               || (XLEN == 32 && (funct3 == F3_DOUBLEWORD || funct3 == F3_WORD_UNSIGNED))
               || (opcode == OPC_STORE && funct3[2]);
        misaligned = |(address[2:0] & align_mask(funct3[1:0]));
        dec_error  = ERR_OK;
        if (illegal)
            dec_error = ERR_ILLEGAL;
`ifndef LSU_MISALIGNED_SPLIT_EN
        else if (misaligned)
            dec_error = ERR_MISALIGNED;
`endif
    end

    assign aligned_addr = ADDRESS_WIDTH'(address) & ~ADDRESS_WIDTH'(NB - 1);

    // The aligner sees the live request in IDLE and the captured one afterwards.
    assign in_idle   = (state == S_IDLE);
    assign la_funct3 = in_idle ? funct3 : op_funct3;
    assign la_offset = in_idle ? address[OW-1:0] : op_offset;
`ifdef LSU_MISALIGNED_SPLIT_EN
    assign la_rdata_lo = (state == S_ACCESS2) ? rdata_lo : mem.mem_rdata;
`else
    assign la_rdata_lo = mem.mem_rdata;
`endif

    load_store_controller_lane_align #(.XLEN(XLEN)) u_lane_align (
        .funct3     (la_funct3),
        .offset     (la_offset),
        .store_data (store_data),
        .rdata_lo   (la_rdata_lo),
`ifdef LSU_MISALIGNED_SPLIT_EN
        .rdata_hi   (mem.mem_rdata),
        .wmask_hi   (la_wmask_hi),
        .wdata_hi   (la_wdata_hi),
`endif
        .wmask      (la_wmask),
        .wdata      (la_wdata),
        .load_data  (la_load)
    );

    always_ff @(posedge CLK) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        mem.mem_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_next = (dec_error != ERR_OK) ? S_RESP : S_ACCESS;
            end
            S_ACCESS: begin
                mem.mem_valid = 1'b1;
                if (mem.mem_ready) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                    state_next = op_split ? S_ACCESS2 : S_RESP;
`else
                    state_next = S_RESP;
`endif
                end
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            S_ACCESS2: begin
                mem.mem_valid = 1'b1;
                if (mem.mem_ready) state_next = S_RESP;
            end
`endif
            S_RESP: begin
                resp_valid = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            op_write      <= 1'b0;
            op_funct3     <= 3'b000;
            op_offset     <= '0;
            mem.mem_write <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wmask <= '0;
            mem.mem_wdata <= '0;
            resp_error    <= ERR_OK;
            load_data     <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            op_split      <= 1'b0;
            wmask_hi      <= '0;
            wdata_hi      <= '0;
            rdata_lo      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    op_write      <= (opcode == OPC_STORE);
                    op_funct3     <= funct3;
                    op_offset     <= address[OW-1:0];
                    mem.mem_write <= (opcode == OPC_STORE) && !illegal;
                    mem.mem_addr  <= aligned_addr;
                    mem.mem_wmask <= la_wmask;
                    mem.mem_wdata <= la_wdata;
                    resp_error    <= dec_error;
                    load_data     <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
                    op_split      <= misaligned && !illegal;
                    wmask_hi      <= la_wmask_hi;
                    wdata_hi      <= la_wdata_hi;
`endif
                end
                S_ACCESS: if (mem.mem_ready) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                    if (op_split) begin
                        rdata_lo      <= mem.mem_rdata;
                        mem.mem_addr  <= mem.mem_addr + ADDRESS_WIDTH'(NB);
                        mem.mem_wmask <= wmask_hi;
                        mem.mem_wdata <= wdata_hi;
                    end else
`endif
                    load_data <= op_write ? '0 : la_load;
                end
`ifdef LSU_MISALIGNED_SPLIT_EN
                S_ACCESS2: if (mem.mem_ready) load_data <= op_write ? '0 : la_load;
`endif
                default: ;
            endcase
        end
    end

endmodule
